// File: rtl/pwm_gener_multi.sv
// N-channel PWM generator: tick prescaler, runtime period, live per-channel polarity,
// and period/duty shadow registers loaded only at frame boundaries via request/acknowledge.
module pwm_gener_multi #(
  parameter int CH_NUM     = 8,
  parameter int CNT_W      = 16,
  parameter int DIV        = 50,
  parameter int DEF_PERIOD = 2499
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    En,
  input  logic [CNT_W-1:0]        Period,
  input  logic [CH_NUM*CNT_W-1:0] Duty,
  input  logic [CH_NUM-1:0]       Pol,
  input  logic                    Upd_Req,
  output logic                    Upd_Ack,
  output logic [CH_NUM-1:0]       Sig_Out,
  output logic                    Frame_Start
);
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(DIV - 1);

  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  per_sh_q, per_sh_d;
  logic [CNT_W-1:0]  duty_sh_q [CH_NUM];
  logic [CNT_W-1:0]  duty_sh_d [CH_NUM];
  logic              pend_q, pend_d;
  logic              en_q, en_d;
  logic              ack_q, ack_d;
  logic              fs_q, fs_d;
  logic [CH_NUM-1:0] sig_q, sig_d;
  logic              tick, wrap, load;

  always_comb begin
    tick = En && (tcnt_q == TCNT_LAST);
    wrap = tick && (fcnt_q == per_sh_q);
    load = (pend_q || Upd_Req) && (wrap || !En);

    tcnt_d = '0;
    if (En && !tick) tcnt_d = tcnt_q + TW'(1);

    fcnt_d = fcnt_q;
    if (!En || wrap)  fcnt_d = '0;
    else if (tick)    fcnt_d = fcnt_q + CNT_W'(1);

    per_sh_d = load ? Period : per_sh_q;
    pend_d   = !load && (pend_q || Upd_Req);
    ack_d    = load;
    en_d     = En;
    fs_d     = wrap || (En && !en_q);

    // Compare on next-cycle counter and shadow so a new frame's widths start on its Frame_Start cycle
    duty_sh_d = duty_sh_q;
    sig_d     = Pol;
    for (int i = 0; i < CH_NUM; i++) begin
      if (load) duty_sh_d[i] = Duty[i*CNT_W +: CNT_W];
      if (En)   sig_d[i] = (fcnt_d < duty_sh_d[i]) ^ Pol[i];
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      tcnt_q   <= '0;
      fcnt_q   <= '0;
      per_sh_q <= CNT_W'(DEF_PERIOD);
      for (int i = 0; i < CH_NUM; i++) duty_sh_q[i] <= '0;
      pend_q   <= 1'b0;
      en_q     <= 1'b0;
      ack_q    <= 1'b0;
      fs_q     <= 1'b0;
      sig_q    <= '0;
    end else begin
      tcnt_q    <= tcnt_d;
      fcnt_q    <= fcnt_d;
      per_sh_q  <= per_sh_d;
      duty_sh_q <= duty_sh_d;
      pend_q    <= pend_d;
      en_q      <= en_d;
      ack_q     <= ack_d;
      fs_q      <= fs_d;
      sig_q     <= sig_d;
    end
  end

  assign Upd_Ack     = ack_q;
  assign Frame_Start = fs_q;
  assign Sig_Out     = sig_q;

endmodule
